can_wb_reg_master: RTL and testbench
====================================

Name: can_wb_reg_master

Overview:
- Synthesizable Wishbone master that sits directly upstream of the CAN controller's Wishbone slave port.
- Turns single register-access commands (valid/ready) into Wishbone classic cycles.
- Returns read data or a timeout error on a valid/ready response channel.
- Used by the on-chip host path and by the UVM driver's RTL-driven mode in place of the behavioural write/read tasks.

Parameters:
ADDR_W, 8, Wishbone address width (CAN register map 0x00-0xFF)
DATA_W, 8, Wishbone data width
TIMEOUT_CYCLES, 1000, max cycles cyc/stb stay asserted without ack before the access aborts
TO_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width (derived; do not override)

Ports:
clk_i  in  1  core/Wishbone clock; all logic on the rising edge
rst_n_i  in  1  asynchronous active-low reset
cmd_valid_i  in  1  command present
cmd_ready_o  out  1  command accepted when valid&&ready
cmd_we_i  in  1  1 = write, 0 = read
cmd_addr_i  in  ADDR_W  register address
cmd_wdata_i  in  DATA_W  write data (ignored on reads)
rsp_valid_o  out  1  response present
rsp_ready_i  in  1  response consumed when valid&&ready
rsp_rdata_o  out  DATA_W  read data; 0 for writes and on error
rsp_err_o  out  1  1 = access timed out
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_we_o  out  1  Wishbone write enable
wb_adr_o  out  ADDR_W  Wishbone address
wb_dat_o  out  DATA_W  Wishbone write data
wb_dat_i  in  DATA_W  Wishbone read data
wb_ack_i  in  1  Wishbone acknowledge
stray_ack_o  out  1  sticky: ack seen outside an active cycle; cleared only by reset

Behaviour:
- Reset (async assert, sync-safe deassert): state IDLE; every output 0 except cmd_ready_o = 1; timeout counter 0. Reset mid-access drops cyc/stb immediately and loses the in-flight command with no response.
- All Wishbone outputs and response outputs are registered.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - cmd_ready_o = 1.
  - On valid&&ready at edge N: latch we/addr/wdata onto the wb_* outputs, drive wb_cyc_o = wb_stb_o = 1 from after edge N, clear counter, go to REQ.
- REQ:
  - cmd_ready_o = 0; counter increments each edge.
  - wb_ack_i high at an edge:
    - cyc/stb/we drop to 0 after that edge.
    - Read: rsp_rdata_o <= wb_dat_i. Write: rsp_rdata_o <= 0.
    - rsp_err_o <= 0, rsp_valid_o <= 1, go to RESP.
  - Counter reaches TIMEOUT_CYCLES-1 with no ack:
    - cyc/stb/we drop.
    - rsp_err_o <= 1, rsp_rdata_o <= 0, rsp_valid_o <= 1, go to RESP.
  - Ack on the same edge as the timeout: ack wins and the access completes normally.
- Minimum latency: ack at edge N+1 puts rsp_valid_o high after N+1. Ack combinationally on first stb: 1-cycle Wishbone cycle.
- RESP:
  - rsp_* held stable while rsp_ready_i = 0.
  - On rsp_ready_i: rsp_valid_o <= 0, rsp_err_o <= 0, go to IDLE.
  - The next command is accepted no earlier than the following edge, so cyc is low for at least 1 cycle between accesses.
- wb_adr_o, wb_dat_o and wb_we_o hold their values while cyc = 1. After cyc drops, adr/dat keep their last value (no X).
- wb_ack_i high while cyc_o = 0 (IDLE/RESP): ignored for data; sets stray_ack_o.
- cmd inputs changing while cmd_ready_o = 0 have no effect.

Decomposition:
- Package can_wb_pkg:
  - typedef enum logic [1:0] {IDLE, REQ, RESP} wbm_state_e
  - localparam CAN_ADDR_W = 8, CAN_DATA_W = 8, CAN_WB_TIMEOUT = 1000
  - typedef struct wb_cmd_t {we, addr, wdata}
  - typedef struct wb_rsp_t {rdata, err}
- Sub-module can_wb_timeout_cnt:
  - Loadable counter with clear/enable inputs.
  - Outputs an expired flag at TIMEOUT_CYCLES-1.
- FSM and datapath in the top module.

Test Plan:
- Write 0x00 <- 0x01; slave acks 2 cycles after stb -> wb_we_o = 1, adr = 0x00, dat = 0x01 on the bus; cyc high exactly 3 cycles; response err = 0, rdata = 0x00.
- Read 0x1F; slave returns 0xA5 with ack on the first stb cycle -> cyc high 1 cycle; rsp_rdata_o = 0xA5, err = 0.
- Read 0x04 with no ack, TIMEOUT_CYCLES = 16 -> cyc drops after exactly 16 cycles; err = 1, rdata = 0x00; next command accepted normally.
- Ack asserted on the same edge the counter expires (TIMEOUT_CYCLES = 16, ack at cycle 16) -> err = 0, read data captured.
- Hold rsp_ready_i = 0 for 5 cycles with cmd_valid_i held high -> rsp stable, cmd_ready_o = 0, no new cyc; after ready, one idle cycle, then the next access starts.
- Pulse wb_ack_i in IDLE -> stray_ack_o = 1 and stays set. Assert rst_n_i = 0 mid-REQ -> cyc/stb/rsp_valid go to 0 immediately and cmd_ready_o = 1.

Source files
------------

// File: rtl/can_wb_pkg.sv
// Shared types and defaults for the CAN register-access Wishbone master.
package can_wb_pkg;

   localparam int CAN_ADDR_W     = 8;
   localparam int CAN_DATA_W     = 8;
   localparam int CAN_WB_TIMEOUT = 1000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } wbm_state_e;

   typedef struct packed {
      logic                  we;
      logic [CAN_ADDR_W-1:0] addr;
      logic [CAN_DATA_W-1:0] wdata;
   } wb_cmd_t;

   typedef struct packed {
      logic [CAN_DATA_W-1:0] rdata;
      logic                  err;
   } wb_rsp_t;

endpackage

// File: rtl/can_wb_reg_master_if.sv
// Command, response and Wishbone bus signals of the register master.
// Signal suffixes are from the master's point of view.
interface can_wb_reg_master_if #(
   parameter int ADDR_W = can_wb_pkg::CAN_ADDR_W,
   parameter int DATA_W = can_wb_pkg::CAN_DATA_W
);
   logic              cmd_valid_i;
   logic              cmd_ready_o;
   logic              cmd_we_i;
   logic [ADDR_W-1:0] cmd_addr_i;
   logic [DATA_W-1:0] cmd_wdata_i;

   logic              rsp_valid_o;
   logic              rsp_ready_i;
   logic [DATA_W-1:0] rsp_rdata_o;
   logic              rsp_err_o;

   logic              wb_cyc_o;
   logic              wb_stb_o;
   logic              wb_we_o;
   logic [ADDR_W-1:0] wb_adr_o;
   logic [DATA_W-1:0] wb_dat_o;
   logic [DATA_W-1:0] wb_dat_i;
   logic              wb_ack_i;

   modport master (
      input  cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_wdata_i,
      output cmd_ready_o,
      output rsp_valid_o, rsp_rdata_o, rsp_err_o,
      input  rsp_ready_i,
      output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
      input  wb_dat_i, wb_ack_i
   );

   modport slave (
      output cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_wdata_i,
      input  cmd_ready_o,
      input  rsp_valid_o, rsp_rdata_o, rsp_err_o,
      output rsp_ready_i,
      input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
      output wb_dat_i, wb_ack_i
   );
endinterface

// File: rtl/can_wb_timeout_cnt.sv
// Access watchdog: counts cycles spent waiting for ack and flags when the
// last allowed cycle is reached. Saturates there so it never wraps.
module can_wb_timeout_cnt #(
   parameter int TIMEOUT_CYCLES = can_wb_pkg::CAN_WB_TIMEOUT,
   parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);
   localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] cnt_q;

   assign expired_o = (cnt_q == LAST);

   // clear on a new access, otherwise count up while enabled
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i && !expired_o) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end
endmodule

// File: rtl/can_wb_reg_master.sv
// Single-access Wishbone classic master in front of the CAN controller's
// register port. One command in, one Wishbone cycle, one response out.
//
// state | meaning
// IDLE  | ready for a command, bus idle
// REQ   | cyc/stb asserted, waiting for ack or timeout
// RESP  | response held until consumed
module can_wb_reg_master
   import can_wb_pkg::*;
#(
   parameter int ADDR_W         = CAN_ADDR_W,
   parameter int DATA_W         = CAN_DATA_W,
   parameter int TIMEOUT_CYCLES = CAN_WB_TIMEOUT
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   can_wb_reg_master_if.master  bus,
   output logic                 stray_ack_o
);
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   wbm_state_e        state_q, state_d;
   logic              cyc_q, cyc_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] adr_q, adr_d;
   logic [DATA_W-1:0] dat_q, dat_d;
   logic              rvalid_q, rvalid_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              stray_q;
   logic              cnt_clr, cnt_en, cnt_expired;

   can_wb_timeout_cnt #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TO_W           (TO_W)
   ) u_timeout (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .clr_i     (cnt_clr),
      .en_i      (cnt_en),
      .expired_o (cnt_expired)
   );

   assign bus.cmd_ready_o = (state_q == IDLE);
   assign bus.wb_cyc_o    = cyc_q;
   assign bus.wb_stb_o    = cyc_q;
   assign bus.wb_we_o     = we_q;
   assign bus.wb_adr_o    = adr_q;
   assign bus.wb_dat_o    = dat_q;
   assign bus.rsp_valid_o = rvalid_q;
   assign bus.rsp_rdata_o = rdata_q;
   assign bus.rsp_err_o   = err_q;
   assign stray_ack_o     = stray_q;

   // next state and next register values; ack takes priority over timeout
   always_comb begin
      state_d  = state_q;
      cyc_d    = cyc_q;
      we_d     = we_q;
      adr_d    = adr_q;
      dat_d    = dat_q;
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      cnt_clr  = 1'b0;
      cnt_en   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.cmd_valid_i) begin
               cyc_d   = 1'b1;
               we_d    = bus.cmd_we_i;
               adr_d   = bus.cmd_addr_i;
               dat_d   = bus.cmd_wdata_i;
               cnt_clr = 1'b1;
               state_d = REQ;
            end
         end
         REQ: begin
            cnt_en = 1'b1;
            if (bus.wb_ack_i) begin
               cyc_d    = 1'b0;
               we_d     = 1'b0;
               rdata_d  = we_q ? '0 : bus.wb_dat_i;
               err_d    = 1'b0;
               rvalid_d = 1'b1;
               state_d  = RESP;
            end else if (cnt_expired) begin
               cyc_d    = 1'b0;
               we_d     = 1'b0;
               rdata_d  = '0;
               err_d    = 1'b1;
               rvalid_d = 1'b1;
               state_d  = RESP;
            end
         end
         RESP: begin
            if (bus.rsp_ready_i) begin
               rvalid_d = 1'b0;
               err_d    = 1'b0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state and registered bus/response outputs
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= IDLE;
         cyc_q    <= 1'b0;
         we_q     <= 1'b0;
         adr_q    <= '0;
         dat_q    <= '0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cyc_q    <= cyc_d;
         we_q     <= we_d;
         adr_q    <= adr_d;
         dat_q    <= dat_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   // sticky flag for an ack arriving while no cycle is open
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         stray_q <= 1'b0;
      end else if (bus.wb_ack_i && !cyc_q) begin
         stray_q <= 1'b1;
      end
   end
endmodule

// File: tb/tb_can_wb_reg_master.sv
// Bench for can_wb_reg_master: directed cases plus a randomized run, each
// access checked against the expected cycle length and response.
module tb_can_wb_reg_master;
   import can_wb_pkg::*;

   localparam int T = 16;

   logic clk_i = 1'b0;
   logic rst_n_i = 1'b0;
   logic stray_ack_o;

   always #5 clk_i = ~clk_i;

   can_wb_reg_master_if #(.ADDR_W(8), .DATA_W(8)) bus ();

   can_wb_reg_master #(
      .ADDR_W         (8),
      .DATA_W         (8),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .bus         (bus),
      .stray_ack_o (stray_ack_o)
   );

   int n_checks = 0;
   int n_errors = 0;
   bit chain_pend = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic wb_cmd_t mk(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
      wb_cmd_t c;
      c.we    = we;
      c.addr  = addr;
      c.wdata = wdata;
      return c;
   endfunction

   task automatic check_idle(input string tag);
      check({tag, "_cyc"},    bus.wb_cyc_o, 0);
      check({tag, "_stb"},    bus.wb_stb_o, 0);
      check({tag, "_we"},     bus.wb_we_o, 0);
      check({tag, "_adr"},    bus.wb_adr_o, 0);
      check({tag, "_dat"},    bus.wb_dat_o, 0);
      check({tag, "_rvalid"}, bus.rsp_valid_o, 0);
      check({tag, "_rdata"},  bus.rsp_rdata_o, 0);
      check({tag, "_err"},    bus.rsp_err_o, 0);
      check({tag, "_ready"},  bus.cmd_ready_o, 1);
      check({tag, "_stray"},  stray_ack_o, 0);
   endtask

   // lat: cycle of the Wishbone access (1 = first stb cycle) in which the
   // slave acks; 0 = never. rd: data the slave returns with its ack.
   task automatic run_access(input wb_cmd_t c, input logic [7:0] rd, input int lat,
                             input int rdy_wait, input bit chain_out, input wb_cmd_t nxt);
      int waits;
      int len;
      bit ack_in_time;
      int exp_len;
      logic exp_err;
      logic [7:0] exp_rdata;

      ack_in_time = (lat != 0) && (lat <= T);
      exp_len     = ack_in_time ? lat : T;
      exp_err     = !ack_in_time;
      exp_rdata   = (ack_in_time && !c.we) ? rd : 8'h00;

      if (!chain_pend) begin
         @(negedge clk_i);
         bus.cmd_valid_i = 1'b1;
         bus.cmd_we_i    = c.we;
         bus.cmd_addr_i  = c.addr;
         bus.cmd_wdata_i = c.wdata;
      end
      chain_pend = 1'b0;

      waits = 0;
      do begin
         @(negedge clk_i);
         waits++;
      end while (!bus.wb_cyc_o && waits < 10);
      check("accept_lat", waits, 1);
      if (!bus.wb_cyc_o) begin
         bus.cmd_valid_i = 1'b0;
         return;
      end

      len = 0;
      while (bus.wb_cyc_o && len < 4 * T) begin
         len++;
         check("stb", bus.wb_stb_o, 1);
         check("we", bus.wb_we_o, c.we);
         check("adr", bus.wb_adr_o, c.addr);
         if (c.we) check("dat", bus.wb_dat_o, c.wdata);
         check("ready_busy", bus.cmd_ready_o, 0);
         bus.cmd_valid_i = 1'($urandom_range(0, 1));
         bus.cmd_we_i    = 1'($urandom_range(0, 1));
         bus.cmd_addr_i  = 8'($urandom);
         bus.cmd_wdata_i = 8'($urandom);
         bus.wb_ack_i    = (len == lat);
         bus.wb_dat_i    = (len == lat) ? rd : 8'($urandom);
         @(negedge clk_i);
      end
      bus.wb_ack_i = 1'b0;

      check("cyc_len", len, exp_len);
      check("rsp_valid", bus.rsp_valid_o, 1);
      check("rsp_err", bus.rsp_err_o, exp_err);
      check("rsp_rdata", bus.rsp_rdata_o, exp_rdata);
      check("stb_drop", bus.wb_stb_o, 0);
      check("we_drop", bus.wb_we_o, 0);
      check("adr_keep", bus.wb_adr_o, c.addr);
      if (c.we) check("dat_keep", bus.wb_dat_o, c.wdata);

      bus.cmd_valid_i = 1'b1;
      for (int i = 0; i < rdy_wait; i++) begin
         @(negedge clk_i);
         check("hold_valid", bus.rsp_valid_o, 1);
         check("hold_err", bus.rsp_err_o, exp_err);
         check("hold_rdata", bus.rsp_rdata_o, exp_rdata);
         check("hold_ready", bus.cmd_ready_o, 0);
         check("hold_cyc", bus.wb_cyc_o, 0);
         bus.cmd_addr_i = 8'($urandom);
      end

      if (chain_out) begin
         bus.cmd_valid_i = 1'b1;
         bus.cmd_we_i    = nxt.we;
         bus.cmd_addr_i  = nxt.addr;
         bus.cmd_wdata_i = nxt.wdata;
      end else begin
         bus.cmd_valid_i = 1'b0;
      end
      bus.rsp_ready_i = 1'b1;
      @(negedge clk_i);
      bus.rsp_ready_i = 1'b0;
      check("rel_valid", bus.rsp_valid_o, 0);
      check("rel_err", bus.rsp_err_o, 0);
      check("rel_ready", bus.cmd_ready_o, 1);
      check("rel_cyc", bus.wb_cyc_o, 0);
      chain_pend = chain_out;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      wb_cmd_t none;
      wb_cmd_t cur;
      wb_cmd_t nxt;
      int lat;
      int sel;
      bit chain;

      none = mk(1'b0, 8'h00, 8'h00);
      bus.cmd_valid_i = 1'b0;
      bus.cmd_we_i    = 1'b0;
      bus.cmd_addr_i  = '0;
      bus.cmd_wdata_i = '0;
      bus.rsp_ready_i = 1'b0;
      bus.wb_dat_i    = '0;
      bus.wb_ack_i    = 1'b0;

      repeat (3) @(negedge clk_i);
      check_idle("rst");
      rst_n_i = 1'b1;
      @(negedge clk_i);
      check_idle("post_rst");

      run_access(mk(1'b1, 8'h00, 8'h01), 8'h00, 3, 0, 1'b0, none);
      run_access(mk(1'b0, 8'h1F, 8'h00), 8'hA5, 1, 0, 1'b0, none);
      run_access(mk(1'b0, 8'h04, 8'h00), 8'h00, 0, 1, 1'b0, none);
      run_access(mk(1'b1, 8'h10, 8'h6E), 8'h00, 2, 0, 1'b0, none);
      run_access(mk(1'b0, 8'h22, 8'h00), 8'h5A, T, 0, 1'b0, none);
      run_access(mk(1'b0, 8'h30, 8'h00), 8'h3C, 2, 5, 1'b1, mk(1'b1, 8'h31, 8'h77));
      run_access(mk(1'b1, 8'h31, 8'h77), 8'h00, 1, 0, 1'b0, none);
      check("stray_none_directed", stray_ack_o, 0);

      cur = mk(1'($urandom), 8'($urandom), 8'($urandom));
      for (int i = 0; i < 40; i++) begin
         nxt = mk(1'($urandom), 8'($urandom), 8'($urandom));
         sel = $urandom_range(0, 9);
         case (sel)
            0:       lat = 0;
            1:       lat = T - 1;
            2:       lat = T;
            3:       lat = T + 2;
            default: lat = $urandom_range(1, 4);
         endcase
         chain = (i < 39) && ($urandom_range(0, 1) == 1);
         run_access(cur, 8'($urandom), lat, $urandom_range(0, 3), chain, nxt);
         cur = nxt;
      end
      check("stray_none_random", stray_ack_o, 0);

      @(negedge clk_i);
      bus.wb_ack_i = 1'b1;
      @(negedge clk_i);
      bus.wb_ack_i = 1'b0;
      check("stray_set", stray_ack_o, 1);
      @(negedge clk_i);
      check("stray_sticky", stray_ack_o, 1);
      run_access(mk(1'b0, 8'h05, 8'h00), 8'h99, 2, 0, 1'b0, none);
      check("stray_after_access", stray_ack_o, 1);

      @(negedge clk_i);
      bus.cmd_valid_i = 1'b1;
      bus.cmd_we_i    = 1'b0;
      bus.cmd_addr_i  = 8'h40;
      @(negedge clk_i);
      bus.cmd_valid_i = 1'b0;
      check("rst_mid_cyc_before", bus.wb_cyc_o, 1);
      #2 rst_n_i = 1'b0;
      #1;
      check("rst_mid_cyc", bus.wb_cyc_o, 0);
      check("rst_mid_stb", bus.wb_stb_o, 0);
      check("rst_mid_rvalid", bus.rsp_valid_o, 0);
      check("rst_mid_ready", bus.cmd_ready_o, 1);
      check("rst_mid_stray", stray_ack_o, 0);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      @(negedge clk_i);
      check_idle("after_mid_rst");
      run_access(mk(1'b1, 8'h7F, 8'hC3), 8'h00, 3, 2, 1'b0, none);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
